// File: rtl/rr_reg_arbiter.sv
// -----------------------------------------------------------------------------
// rr_reg_arbiter
//
// Four requesters share one 8-bit register. Each transaction is granted by
// round-robin arbitration, runs through a fixed three-cycle sequence and
// applies one read-modify-write operation to the register. A rotating pointer
// marks the requester with the highest priority. After requester i is served,
// the pointer moves to i+1, so a requester that keeps requesting waits behind
// the others.
//
// Ports
//   clk    in   1   clock, rising edge
//   rst_n  in   1   synchronous active-low reset
//   req    in   4   level request, bit i = requester i
//   op     in   8   opcode per requester, op[2i+1:2i]
//                   00 load, 01 set bits, 10 clear bits, 11 toggle bits
//   wdata  in  32   operand per requester, wdata[8i+7:8i]
//   gnt    out  4   one-hot grant, high for the GRANT cycle
//   ack    out  4   one-hot completion pulse, high for the ACK cycle
//   rdata  out  8   register value after the operation, only during ACK
//   reg_q  out  8   shared register
//   busy   out  1   transaction in flight (GRANT or ACK)
//
// States
//   state    | meaning
//   ST_IDLE  | waiting for a request; arbitrates and captures the winner
//   ST_GRANT | gnt asserted; the register is updated at the end of this cycle
//   ST_ACK   | ack and rdata asserted; the pointer has already rotated
// -----------------------------------------------------------------------------
module rr_reg_arbiter #(
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic [7:0]  op,
  input  logic [31:0] wdata,
  output logic [3:0]  gnt,
  output logic [3:0]  ack,
  output logic [7:0]  rdata,
  output logic [7:0]  reg_q,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_ACK   = 2'd2
  } state_t;

  localparam logic [1:0] OP_LOAD   = 2'b00;
  localparam logic [1:0] OP_SET    = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  state_t      state_q;
  logic [1:0]  ptr_q;
  logic [1:0]  win_q;
  logic [1:0]  op_q;
  logic [7:0]  wdata_q;

  logic        win_found;
  logic [1:0]  win_idx;
  logic [1:0]  cand;
  logic [1:0]  sel_op;
  logic [7:0]  sel_wdata;
  logic [7:0]  reg_d;

  function automatic logic [7:0] apply_op(input logic [1:0] opc,
                                          input logic [7:0] cur,
                                          input logic [7:0] opnd);
    logic [7:0] res;
    case (opc)
      OP_LOAD:   res = opnd;
      OP_SET:    res = cur | opnd;
      OP_CLEAR:  res = cur & ~opnd;
      OP_TOGGLE: res = cur ^ opnd;
      default:   res = cur;
    endcase
    return res;
  endfunction

  // The search starts at the pointer and wraps modulo 4 because the 2-bit
  // sum overflows. The first requesting index it finds wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    cand      = ptr_q;
    for (int k = 0; k < 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign sel_op    = op[{win_idx, 1'b0} +: 2];
  assign sel_wdata = wdata[{win_idx, 3'b000} +: 8];

  // The operation uses the operands captured when the grant was issued.
  // Requesters may change their inputs during GRANT without any effect.
  assign reg_d = apply_op(op_q, reg_q, wdata_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      reg_q   <= RESET_VAL;
      gnt     <= 4'b0000;
      ack     <= 4'b0000;
      rdata   <= 8'h00;
      busy    <= 1'b0;
      ptr_q   <= 2'd0;
      win_q   <= 2'd0;
      op_q    <= 2'd0;
      wdata_q <= 8'h00;
    end else begin
      case (state_q)
        ST_IDLE: begin
          ack   <= 4'b0000;
          rdata <= 8'h00;
          if (win_found) begin
            state_q <= ST_GRANT;
            win_q   <= win_idx;
            op_q    <= sel_op;
            wdata_q <= sel_wdata;
            gnt     <= 4'b0001 << win_idx;
            busy    <= 1'b1;
          end else begin
            gnt  <= 4'b0000;
            busy <= 1'b0;
          end
        end

        ST_GRANT: begin
          state_q <= ST_ACK;
          reg_q   <= reg_d;
          rdata   <= reg_d;
          gnt     <= 4'b0000;
          ack     <= 4'b0001 << win_q;
          busy    <= 1'b1;
          ptr_q   <= win_q + 2'd1;
        end

        ST_ACK: begin
          state_q <= ST_IDLE;
          gnt     <= 4'b0000;
          ack     <= 4'b0000;
          rdata   <= 8'h00;
          busy    <= 1'b0;
        end

        default: begin
          state_q <= ST_IDLE;
          gnt     <= 4'b0000;
          ack     <= 4'b0000;
          rdata   <= 8'h00;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_reg_arbiter.sv
module tb_rr_reg_arbiter;

  localparam logic [7:0] RV = 8'h5A;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [7:0]  op;
  logic [31:0] wdata;
  logic [3:0]  gnt;
  logic [3:0]  ack;
  logic [7:0]  rdata;
  logic [7:0]  reg_q;
  logic        busy;

  int checks = 0;
  int errors = 0;

  rr_reg_arbiter #(.RESET_VAL(RV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .op    (op),
    .wdata (wdata),
    .gnt   (gnt),
    .ack   (ack),
    .rdata (rdata),
    .reg_q (reg_q),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transaction-level reference model. A transaction takes three cycles.
  // m_left counts the cycles that remain in the transaction in flight.
  logic [7:0] m_reg;
  int         m_ptr;
  int         m_left;
  int         m_win;
  logic [1:0] m_op;
  logic [7:0] m_wd;
  logic [3:0] e_gnt;
  logic [3:0] e_ack;
  logic [7:0] e_rdata;
  logic       e_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    e_gnt   = 4'b0000;
    e_ack   = 4'b0000;
    e_rdata = 8'h00;
    e_busy  = 1'b0;
    if (!rst_n) begin
      m_reg  = RV;
      m_ptr  = 0;
      m_left = 0;
    end else if (m_left == 0) begin
      if (req != 4'b0000) begin
        m_win = -1;
        for (int k = 0; k < 4; k++)
          if (m_win < 0 && req[(m_ptr + k) % 4]) m_win = (m_ptr + k) % 4;
        m_op   = op[2*m_win +: 2];
        m_wd   = wdata[8*m_win +: 8];
        e_gnt  = 4'b0001 << m_win;
        e_busy = 1'b1;
        m_left = 2;
      end
    end else if (m_left == 2) begin
      case (m_op)
        2'b00:   m_reg = m_wd;
        2'b01:   m_reg = m_reg | m_wd;
        2'b10:   m_reg = m_reg & ~m_wd;
        default: m_reg = m_reg ^ m_wd;
      endcase
      e_ack   = 4'b0001 << m_win;
      e_rdata = m_reg;
      e_busy  = 1'b1;
      m_ptr   = (m_win + 1) % 4;
      m_left  = 1;
    end else begin
      m_left = 0;
    end
  endtask

  task automatic check_all();
    chk("gnt", 32'(gnt), 32'(e_gnt));
    chk("ack", 32'(ack), 32'(e_ack));
    chk("rdata", 32'(rdata), 32'(e_rdata));
    chk("reg_q", 32'(reg_q), 32'(m_reg));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("gnt_ack_exclusive", 32'((gnt != 4'b0) && (ack != 4'b0)), 32'd0);
    chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
    chk("ack_onehot0", 32'($onehot0(ack)), 32'd1);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic drive(input int idx, input logic [1:0] opc, input logic [7:0] d);
    req = 4'b0001 << idx;
    op[2*idx +: 2] = opc;
    wdata[8*idx +: 8] = d;
  endtask

  // Runs one full transaction for requester idx. The request is dropped after
  // the grant, and the ACK value is compared with a hand-computed constant.
  task automatic txn(input int idx, input logic [1:0] opc, input logic [7:0] d,
                     input logic [7:0] exp_val);
    drive(idx, opc, d);
    step();
    chk("txn_gnt", 32'(gnt), 32'(4'b0001 << idx));
    req = 4'b0000;
    step();
    chk("txn_ack", 32'(ack), 32'(4'b0001 << idx));
    chk("txn_rdata", 32'(rdata), 32'(exp_val));
    step();
    chk("txn_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    op    = 8'h00;
    wdata = 32'h0;
    m_reg = 8'h00; m_ptr = 0; m_left = 0; m_win = 0; m_op = 2'b00; m_wd = 8'h00;

    step();
    step();
    chk("reset_reg", 32'(reg_q), 32'(RV));
    chk("reset_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    step();

    // Single load, followed by set, clear and toggle.
    txn(0, 2'b00, 8'hA5, 8'hA5);
    txn(1, 2'b01, 8'h0F, 8'hAF);
    txn(2, 2'b10, 8'hA0, 8'h0F);
    txn(3, 2'b11, 8'hFF, 8'hF0);

    // All requesters held: strict rotation, one grant every 3 cycles.
    req   = 4'b1111;
    op    = 8'b01_00_11_00;
    wdata = 32'h8040_2010;
    for (int n = 0; n < 12; n++) begin
      step();
      chk("rr_gnt", 32'(gnt), 32'(4'b0001 << (n % 4)));
      step();
      chk("rr_ack", 32'(ack), 32'(4'b0001 << (n % 4)));
      step();
    end
    req = 4'b0000;
    step();

    // Wrap: after serving requester 2, requester 3 outranks requester 0.
    txn(2, 2'b00, 8'h3C, 8'h3C);
    req = 4'b1001;
    step();
    chk("wrap_gnt", 32'(gnt), 32'h8);
    req = 4'b0000;
    step();
    step();

    // Input change during GRANT has no effect on the captured transaction.
    txn(0, 2'b00, 8'h30, 8'h30);
    drive(0, 2'b01, 8'h0C);
    step();
    chk("inflight_gnt", 32'(gnt), 32'h1);
    req = 4'b0000;
    op[1:0] = 2'b11;
    wdata[7:0] = 8'hFF;
    step();
    chk("inflight_ack", 32'(ack), 32'h1);
    chk("inflight_reg", 32'(reg_q), 32'h3C);
    step();

    // Reset during GRANT aborts the transaction and resets the pointer.
    drive(2, 2'b00, 8'h77);
    step();
    chk("abort_gnt", 32'(gnt), 32'h4);
    rst_n = 1'b0;
    step();
    chk("abort_reg", 32'(reg_q), 32'(RV));
    chk("abort_ack", 32'(ack), 32'h0);
    rst_n = 1'b1;
    req = 4'b1111;
    step();
    chk("abort_ptr_gnt", 32'(gnt), 32'h1);
    req = 4'b0000;
    step();
    step();

    // Random traffic with occasional resets.
    for (int n = 0; n < 600; n++) begin
      rst_n = ($urandom_range(0, 59) != 0);
      req   = 4'($urandom);
      op    = 8'($urandom);
      wdata = $urandom;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
